// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide controller.
//   op_e        : operation encodings on the op port
//   state_e     : controller FSM state encodings
//   MULDIV_WIDTH: default operand width
//   cnt_w()     : iteration counter width for a given operand width
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic int cnt_w(int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int MULDIV_CNT_W = cnt_w(MULDIV_WIDTH);

  // Even op codes are the signed variants.
  function automatic logic op_is_signed(logic [2:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_div(logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//   master : EX side (drives start/op/a/b/flush/hi_we/lo_we/wdata)
//   slave  : muldiv_ctrl (drives hi/lo/busy/stall/done/div_by_zero)
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  hi, lo, busy, stall, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output hi, lo, busy, stall, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
//   is_div   : 1 = restoring shift-subtract, 0 = shift-add
//   acc      : multiply {partial product, remaining multiplier bits}
//              divide   {partial remainder, dividend/quotient bits}
//   opnd     : multiplicand magnitude or divisor magnitude
//   acc_next : accumulator after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] rem_sel;
  logic           q_bit;
  logic           unused_rem_msb;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    q_bit   = (shifted >= {1'b0, opnd});
    diff    = shifted - {1'b0, opnd};
    // The selected remainder is always below the divisor, so its top bit is zero.
    rem_sel = q_bit ? diff : shifted;
    if (is_div) begin
      acc_next = {rem_sel[WIDTH-1:0], acc[WIDTH-2:0], q_bit};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  assign unused_rem_msb = rem_sel[WIDTH];

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : muldiv_if.slave (start/op/a/b/flush/hi_we/lo_we/wdata in,
//                hi/lo/busy/stall/done/div_by_zero out)
// Build option: MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU (op 4-7).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; mthi/mtlo writes honoured
// ST_ITER | one radix-2 iteration per cycle, WIDTH cycles
// ST_FIX  | sign correction (and accumulate), write HI/LO, pulse done
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int CW = cnt_w(WIDTH);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, acc_nx;
  logic [WIDTH-1:0]     opnd_q;
  logic                 is_div_q, neg_res_q, neg_rem_q, dbz_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q, dbz_out_q;
`ifdef MULDIV_MADD_EN
  logic                 macc_q, sub_q;
`endif

  logic                 op_legal, accept, load, fin, cnt_last;
  logic                 is_div, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s, res_hi, res_lo;

`ifdef MULDIV_MADD_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = !bus.op[2];
`endif

  assign accept   = bus.start && !bus.flush && op_legal;
  assign is_div   = op_is_div(bus.op);
  assign a_neg    = op_is_signed(bus.op) && bus.a[WIDTH-1];
  assign b_neg    = op_is_signed(bus.op) && bus.b[WIDTH-1];
  assign a_mag    = a_neg ? -bus.a : bus.a;
  assign b_mag    = b_neg ? -bus.b : bus.b;
  assign cnt_last = (cnt_q == CW'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        if (bus.flush)     state_d = ST_IDLE;
        else if (cnt_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        fin     = !bus.flush;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Divide-by-zero needs no special remainder path: with a zero divisor every
  // quotient bit is set and the remainder ends as |a|, which the normal
  // remainder sign rule turns back into the original a.
  always_comb begin
    prod_s = neg_res_q ? -acc_q : acc_q;
    quo_s  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    res_hi = hi_q;
    res_lo = lo_q;
    if (is_div_q) begin
      res_hi = rem_s;
      res_lo = dbz_q ? '1 : quo_s;
    end else begin
`ifdef MULDIV_MADD_EN
      if (macc_q && sub_q)  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
      else if (macc_q)      {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      else                  {res_hi, res_lo} = prod_s;
`else
      {res_hi, res_lo} = prod_s;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
`ifdef MULDIV_MADD_EN
      macc_q    <= 1'b0;
      sub_q     <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
      if (load) begin
        cnt_q     <= '0;
        opnd_q    <= is_div ? b_mag : a_mag;
        acc_q     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
        is_div_q  <= is_div;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        dbz_q     <= is_div && (bus.b == '0);
`ifdef MULDIV_MADD_EN
        macc_q    <= bus.op[2];
        sub_q     <= bus.op[2] && bus.op[1];
`endif
      end
      if (state_q == ST_ITER) begin
        acc_q <= acc_nx;
        if (!cnt_last) cnt_q <= cnt_q + CW'(1);
      end
      if (fin) begin
        hi_q      <= res_hi;
        lo_q      <= res_lo;
        done_q    <= 1'b1;
        dbz_out_q <= dbz_q;
      end
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.stall       = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table plus scoreboard, and
// hand-written flush / reset / mthi-mtlo / accumulate sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  vec_t tbl[11];

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Independent reference using native arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    logic signed [W-1:0] qa, qb;
    e.dbz = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    qa = $signed(a);
    qb = $signed(b);
    case (op)
      3'd0: begin sp = sa * sb; {e.hi, e.lo} = sp; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; {e.hi, e.lo} = up; end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dbz = 1'b1;
        end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hi = '0; e.lo = 32'h8000_0000;
        end else if (op == 3'd2) begin
          e.lo = qa / qb; e.hi = qa % qb;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_hi", 64'(bus.hi), 64'(e.hi));
        check("result_lo", 64'(bus.lo), 64'(e.lo));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
      end
    end
  end

  // Called at a falling edge; the following rising edge is the start edge.
  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e);
    exp_q.push_back(e);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at the falling edge just after the start edge.
  task automatic wait_done();
    int edges = 0;
    int busy_n = 0;
    check("stall_eq_busy", 64'(bus.stall), 64'(bus.busy));
    while (!bus.done && edges < 100) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      edges++;
    end
    check("done_latency", 64'(edges), 64'(W + 1));
    check("busy_cycles", 64'(busy_n), 64'(W + 1));
    check("busy_in_done", 64'(bus.busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [W-1:0] d);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = d;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic [2:0] rop;

    tbl[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3]  = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    tbl[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[5]  = '{3'd2, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    tbl[6]  = '{3'd1, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 32'h0001_2340, 1'b0};
    tbl[7]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    tbl[8]  = '{3'd3, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
    tbl[9]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    tbl[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    @(negedge clk);
    check("reset_outputs",
          {bus.hi, bus.lo},
          64'd0);
    check("reset_flags",
          64'({bus.busy, bus.stall, bus.done, bus.div_by_zero}),
          64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dbz = tbl[i].dbz;
      launch(tbl[i].op, tbl[i].a, tbl[i].b, e);
      wait_done();
    end

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i % 4 == 1) rb = -rb;
      launch(rop, ra, rb, model(rop, ra, rb));
      wait_done();
    end

    // mthi together with start: written now, overwritten by the result.
    exp_q.push_back('{32'h0, 32'h6, 1'b0});
    bus.op = 3'd1; bus.a = 32'd2; bus.b = 32'd3;
    bus.start = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'hAB;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    check("hi_we_with_start", 64'(bus.hi), 64'hAB);
    wait_done();

    // Flush mid-operation; start/mtlo attempts while busy must be dropped.
    write_hilo(1'b1, 1'b0, 32'h11);
    write_hilo(1'b0, 1'b1, 32'h22);
    check("preload_hi", 64'(bus.hi), 64'h11);
    check("preload_lo", 64'(bus.lo), 64'h22);
    bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) begin
        bus.start = 1'b1; bus.op = 3'd1; bus.lo_we = 1'b1; bus.wdata = 32'h99;
      end
      if (k == 6) begin
        bus.start = 1'b0; bus.lo_we = 1'b0;
      end
      if (k == 10) bus.flush = 1'b1;
      @(negedge clk);
    end
    bus.flush = 1'b0;
    check("busy_after_flush", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hi", 64'(bus.hi), 64'h11);
    check("flush_lo", 64'(bus.lo), 64'h22);

    // flush in the same cycle as start drops the start.
    bus.op = 3'd1; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("start_with_flush", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-iteration.
    bus.op = 3'd1; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_reset", 64'(bus.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("async_reset_flags", 64'({bus.busy, bus.done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef MULDIV_MADD_EN
    write_hilo(1'b1, 1'b0, 32'h0);
    write_hilo(1'b0, 1'b1, 32'h5);
    launch(3'd4, 32'd3, 32'd4, '{32'h0, 32'd17, 1'b0});
    wait_done();
    launch(3'd6, 32'd3, 32'd5, '{32'h0, 32'd2, 1'b0});
    wait_done();
    launch(3'd6, 32'd1, 32'd3, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
    wait_done();
`else
    write_hilo(1'b1, 1'b1, 32'h77);
    bus.op = 3'd4; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("illegal_op_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    check("illegal_op_hilo", {bus.hi, bus.lo}, 64'h0000_0077_0000_0077);
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
